// File: rtl/decay_sched_pkg.sv
// -----------------------------------------------------------------------------
// decay_sched_pkg
// Shared definitions for the LIF decay scheduler:
//   - decay-rate codes understood by the decay datapath
//   - scheduler state encoding
//   - default initial membrane potential (IEEE-754 single)
//   - is_legal_rate(): true for the five rate codes the datapath implements
// -----------------------------------------------------------------------------
package decay_sched_pkg;

    localparam logic [3:0] RATE_DIV1    = 4'b0001;
    localparam logic [3:0] RATE_DIV2    = 4'b0010;
    localparam logic [3:0] RATE_DIV4    = 4'b0100;
    localparam logic [3:0] RATE_DIV8    = 4'b1000;
    localparam logic [3:0] RATE_DIV2P4  = 4'b0011;

    localparam logic [31:0] DEFAULT_INIT_POTENTIAL = 32'h41DE_D852;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_READ,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    function automatic logic is_legal_rate(input logic [3:0] rate);
        logic legal;
        case (rate)
            RATE_DIV1, RATE_DIV2, RATE_DIV4, RATE_DIV8, RATE_DIV2P4: legal = 1'b1;
            default:                                                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/decay_rate_table.sv
// -----------------------------------------------------------------------------
// decay_rate_table
// Per-neuron decay-rate register file: NUM_NEURONS entries of 4 bits,
// synchronous write, asynchronous read, every entry resets to RATE_DIV1.
// Illegal codes are stored as RATE_DIV1 and latch the sticky bad_rate flag.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   we/waddr/wdata  write port (out-of-range addresses are ignored)
//   raddr/rdata     combinational read port (out-of-range reads give RATE_DIV1)
//   bad_rate        sticky illegal-code flag, cleared only by rst
// -----------------------------------------------------------------------------
module decay_rate_table
    import decay_sched_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [3:0]        rdata,
    output logic              bad_rate
);

    logic [3:0] rate_arr [NUM_NEURONS];
    logic [3:0] wdata_clean;
    logic       bad_rate_reg;

    assign wdata_clean = is_legal_rate(wdata) ? wdata : RATE_DIV1;

    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_slot
            logic [3:0] rate_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rate_reg <= RATE_DIV1;
                end else if (we && (waddr == ADDR_W'(gi))) begin
                    rate_reg <= wdata_clean;
                end
            end

            assign rate_arr[gi] = rate_reg;
        end
    endgenerate

    always_comb begin
        rdata = RATE_DIV1;
        if (int'(raddr) < NUM_NEURONS) begin
            rdata = rate_arr[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_rate_reg <= 1'b0;
        end else if (we && !is_legal_rate(wdata)) begin
            bad_rate_reg <= 1'b1;
        end
    end

    assign bad_rate = bad_rate_reg;

endmodule

// File: rtl/decay_scheduler.sv
// -----------------------------------------------------------------------------
// decay_scheduler
// Sweeps one shared LIF decay datapath across NUM_NEURONS slots per timestep:
// read potential -> load -> issue (valid/ready) -> wait for result -> write
// back. Also performs the initial potential load and owns the rate table.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   init_start, timestep_start       start pulses (init has priority)
//   cfg_we/cfg_addr/cfg_rate         rate-table write port
//   mem_rd_en/addr, mem_rd_data      potential memory read (1-cycle latency)
//   mem_wr_en/addr/data              potential memory write
//   dec_valid/ready/potential/rate   operand handshake to the decay unit
//   dec_result_valid, dec_result     result strobe from the decay unit
//   busy, timestep_done              status; done pulses once per sweep/init
//   overrun, bad_rate                sticky error flags
// Optional build macro DECAY_SKIP_ZERO_EN: slots holding +0/-0 are skipped
// in LOAD (no issue, no write-back).
// -----------------------------------------------------------------------------
module decay_scheduler
    import decay_sched_pkg::*;
#(
    parameter int          NUM_NEURONS    = 30,
    parameter int          ADDR_W         = 5,
    parameter logic [31:0] INIT_POTENTIAL = DEFAULT_INIT_POTENTIAL
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_start,
    input  logic              timestep_start,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_rate,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_potential,
    output logic [3:0]        dec_rate,
    input  logic              dec_result_valid,
    input  logic [31:0]       dec_result,
    output logic              busy,
    output logic              timestep_done,
    output logic              overrun,
    output logic              bad_rate
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_NEURONS - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] index_reg;
    logic [31:0]       pot_reg;
    logic [3:0]        rate_reg;
    logic [31:0]       wr_data_reg;
    logic              rd_en_reg;
    logic              wr_en_reg;
    logic              valid_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              overrun_reg;
    logic [3:0]        table_rate;
    logic              skip_zero;
    logic              is_last;

    decay_rate_table #(
        .NUM_NEURONS (NUM_NEURONS),
        .ADDR_W      (ADDR_W)
    ) u_rate_table (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we),
        .waddr    (cfg_addr),
        .wdata    (cfg_rate),
        .raddr    (index_reg),
        .rdata    (table_rate),
        .bad_rate (bad_rate)
    );

`ifdef DECAY_SKIP_ZERO_EN
    // Ignore the sign bit so both +0 and -0 are skipped.
    assign skip_zero = (mem_rd_data[30:0] == 31'd0);
`else
    assign skip_zero = 1'b0;
`endif

    assign is_last = (index_reg == LAST_INDEX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            index_reg   <= '0;
            pot_reg     <= '0;
            rate_reg    <= '0;
            wr_data_reg <= '0;
            rd_en_reg   <= 1'b0;
            wr_en_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            rd_en_reg <= 1'b0;
            wr_en_reg <= 1'b0;
            done_reg  <= 1'b0;

            // Any start pulse seen outside IDLE is dropped and flagged.
            if ((state_reg != ST_IDLE) && (init_start || timestep_start)) begin
                overrun_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (init_start) begin
                        state_reg   <= ST_INIT;
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= INIT_POTENTIAL;
                        busy_reg    <= 1'b1;
                        if (timestep_start) begin
                            overrun_reg <= 1'b1;
                        end
                    end else if (timestep_start) begin
                        state_reg <= ST_READ;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end

                ST_INIT: begin
                    if (is_last) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        index_reg   <= index_reg + ADDR_W'(1);
                        wr_en_reg   <= 1'b1;
                        wr_data_reg <= INIT_POTENTIAL;
                    end
                end

                ST_READ: begin
                    state_reg <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (skip_zero) begin
                        if (is_last) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            index_reg <= index_reg + ADDR_W'(1);
                            state_reg <= ST_READ;
                            rd_en_reg <= 1'b1;
                        end
                    end else begin
                        // Operands are frozen here and held through ISSUE.
                        pot_reg   <= mem_rd_data;
                        rate_reg  <= table_rate;
                        valid_reg <= 1'b1;
                        state_reg <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (dec_ready) begin
                        valid_reg <= 1'b0;
                        state_reg <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (dec_result_valid) begin
                        wr_data_reg <= dec_result;
                        wr_en_reg   <= 1'b1;
                        state_reg   <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (is_last) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else begin
                        index_reg <= index_reg + ADDR_W'(1);
                        state_reg <= ST_READ;
                        rd_en_reg <= 1'b1;
                    end
                end

                ST_DONE: begin
                    index_reg <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en     = rd_en_reg;
    assign mem_rd_addr   = index_reg;
    assign mem_wr_en     = wr_en_reg;
    assign mem_wr_addr   = index_reg;
    assign mem_wr_data   = wr_data_reg;
    assign dec_valid     = valid_reg;
    assign dec_potential = pot_reg;
    assign dec_rate      = rate_reg;
    assign busy          = busy_reg;
    assign timestep_done = done_reg;
    assign overrun       = overrun_reg;

endmodule

// File: tb/tb_decay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_decay_scheduler
// Directed bench for decay_scheduler: behavioural potential memory and decay
// unit on the negative clock edge, hand-computed expected potentials.
// Honour DECAY_SKIP_ZERO_EN the same way as the design build.
// -----------------------------------------------------------------------------
module tb_decay_scheduler;

    localparam int N  = 30;
    localparam int AW = 5;
    localparam logic [31:0] INIT_P = 32'h41DE_D852;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_start = 1'b0;
    logic          timestep_start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_rate = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data = '0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [31:0]   dec_potential;
    logic [3:0]    dec_rate;
    logic          dec_result_valid = 1'b0;
    logic [31:0]   dec_result = '0;
    logic          busy;
    logic          timestep_done;
    logic          overrun;
    logic          bad_rate;

    always #5 clk = ~clk;

    decay_scheduler #(
        .NUM_NEURONS    (N),
        .ADDR_W         (AW),
        .INIT_POTENTIAL (INIT_P)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .init_start       (init_start),
        .timestep_start   (timestep_start),
        .cfg_we           (cfg_we),
        .cfg_addr         (cfg_addr),
        .cfg_rate         (cfg_rate),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .mem_wr_en        (mem_wr_en),
        .mem_wr_addr      (mem_wr_addr),
        .mem_wr_data      (mem_wr_data),
        .dec_valid        (dec_valid),
        .dec_ready        (dec_ready),
        .dec_potential    (dec_potential),
        .dec_rate         (dec_rate),
        .dec_result_valid (dec_result_valid),
        .dec_result       (dec_result),
        .busy             (busy),
        .timestep_done    (timestep_done),
        .overrun          (overrun),
        .bad_rate         (bad_rate)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Power-of-two decay by exponent adjustment (zero stays zero).
    function automatic logic [31:0] decay_model(input logic [31:0] x, input logic [3:0] r);
        logic [7:0] sh;
        logic [7:0] e;
        case (r)
            4'b0010: sh = 8'd1;
            4'b0100: sh = 8'd2;
            4'b1000: sh = 8'd3;
            default: sh = 8'd0;
        endcase
        e = x[30:23];
        if ((x[30:0] == 31'd0) || (sh == 8'd0)) return x;
        if (e <= sh) return {x[31], 31'd0};
        return {x[31], 8'(e - sh), x[22:0]};
    endfunction

    // Bench-side memory, decay unit and statistics.
    logic [31:0] mem [32];
    int          cyc = 0;
    int          wr_count = 0;
    int          busy_cnt = 0;
    int          done_cnt = 0;
    int          hs_count = 0;
    int          wr_per_addr [32];
    int          issue_cnt [32];
    logic [3:0]  issue_rate [32];
    int          wr_addr_log [64];
    int          wr_cyc_log [64];
    int          cur_slot = 0;
    int          stall_slot = -1;
    int          stall_cycles = 0;
    int          wait_cnt = 0;
    int          valid_cnt_slot = 0;
    logic [31:0] held_pot = '0;
    logic [3:0]  held_rate = '0;
    logic        result_pending = 1'b0;
    logic [31:0] result_val = '0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            wr_per_addr[i] = 0;
            issue_cnt[i] = 0;
            issue_rate[i] = '0;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (busy) busy_cnt++;
        if (timestep_done) done_cnt++;
        if (mem_wr_en) begin
            mem[mem_wr_addr] = mem_wr_data;
            if (wr_count < 64) begin
                wr_addr_log[wr_count] = int'(mem_wr_addr);
                wr_cyc_log[wr_count]  = cyc;
            end
            wr_count++;
            wr_per_addr[mem_wr_addr]++;
        end
        if (mem_rd_en) begin
            mem_rd_data = mem[mem_rd_addr];
            cur_slot    = int'(mem_rd_addr);
        end
        if (result_pending) begin
            dec_result_valid = 1'b1;
            dec_result       = result_val;
            result_pending   = 1'b0;
        end else begin
            dec_result_valid = 1'b0;
        end
        if (dec_valid) begin
            if (cur_slot == stall_slot) valid_cnt_slot++;
            if (wait_cnt == 0) begin
                held_pot  = dec_potential;
                held_rate = dec_rate;
            end else begin
                check_value("dec_potential_stable", dec_potential, held_pot);
                check_value("dec_rate_stable", {28'd0, dec_rate}, {28'd0, held_rate});
            end
            if ((cur_slot == stall_slot) && (wait_cnt < stall_cycles)) begin
                dec_ready = 1'b0;
                wait_cnt++;
            end else begin
                dec_ready = 1'b1;
                hs_count++;
                issue_rate[cur_slot] = dec_rate;
                issue_cnt[cur_slot]++;
                result_val     = decay_model(dec_potential, dec_rate);
                result_pending = 1'b1;
                wait_cnt       = 0;
            end
        end else begin
            dec_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic clear_stats();
        wr_count = 0;
        busy_cnt = 0;
        done_cnt = 0;
        hs_count = 0;
        valid_cnt_slot = 0;
        for (int i = 0; i < 32; i++) begin
            wr_per_addr[i] = 0;
            issue_cnt[i]   = 0;
            issue_rate[i]  = '0;
        end
    endtask

    task automatic cfg_write(input int addr, input logic [3:0] rate);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = AW'(addr);
        cfg_rate = rate;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && (n < 2000)) begin
            @(negedge clk);
            n++;
            if (timestep_done) seen = 1'b1;
        end
        check_value(tag, {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_sweep(input string tag);
        clear_stats();
        @(negedge clk);
        timestep_start = 1'b1;
        @(negedge clk);
        timestep_start = 1'b0;
        wait_done(tag);
        $display("sweep %s: cycles=%0d writes=%0d handshakes=%0d", tag, busy_cnt, wr_count, hs_count);
    endtask

    initial begin
        int bad;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_done", {31'd0, timestep_done}, 32'd0);
        check_value("rst_overrun", {31'd0, overrun}, 32'd0);
        check_value("rst_bad_rate", {31'd0, bad_rate}, 32'd0);
        check_value("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
        check_value("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
        check_value("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        $display("reset: outputs sampled");

        // Init load
        clear_stats();
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        wait_done("init_done");
        check_value("init_writes", wr_count, 32'd30);
        check_value("init_busy_cycles", busy_cnt, 32'd31);
        check_value("init_done_pulses", done_cnt, 32'd1);
        check_value("init_handshakes", hs_count, 32'd0);
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (wr_addr_log[i] != i) bad++;
            if (mem[i] !== INIT_P) bad++;
        end
        check_value("init_addr_data", bad, 32'd0);
        check_value("init_consecutive", wr_cyc_log[N-1] - wr_cyc_log[0], 32'd29);
        $display("init: writes=%0d busy=%0d", wr_count, busy_cnt);

        // Sweep with zero-wait decay unit, slot 3 /2 and slot 10 /8
        cfg_write(3, 4'b0010);
        cfg_write(10, 4'b1000);
        check_value("legal_cfg_bad_rate", {31'd0, bad_rate}, 32'd0);
        run_sweep("basic");
        check_value("sweep_cycles", busy_cnt, 32'd151);
        check_value("sweep_writes", wr_count, 32'd30);
        check_value("sweep_handshakes", hs_count, 32'd30);
        check_value("sweep_done_pulses", done_cnt, 32'd1);
        check_value("slot3_rate", {28'd0, issue_rate[3]}, 32'h2);
        check_value("slot10_rate", {28'd0, issue_rate[10]}, 32'h8);
        check_value("slot0_rate", {28'd0, issue_rate[0]}, 32'h1);
        check_value("slot3_mem", mem[3], 32'h415E_D852);
        check_value("slot10_mem", mem[10], 32'h405E_D852);
        check_value("slot0_mem", mem[0], 32'h41DE_D852);

        // Back-pressure on slot 0
        stall_slot   = 0;
        stall_cycles = 4;
        run_sweep("stall");
        stall_slot   = -1;
        check_value("stall_valid_cycles", valid_cnt_slot, 32'd5);
        check_value("stall_slot0_issues", issue_cnt[0], 32'd1);
        check_value("stall_slot0_writes", wr_per_addr[0], 32'd1);
        check_value("stall_writes", wr_count, 32'd30);
        check_value("stall_cycles", busy_cnt, 32'd155);
        check_value("stall_slot3_mem", mem[3], 32'h40DE_D852);

        // Illegal rate code
        cfg_write(7, 4'b0101);
        check_value("bad_rate_set", {31'd0, bad_rate}, 32'd1);
        run_sweep("bad_rate");
        check_value("slot7_rate", {28'd0, issue_rate[7]}, 32'h1);
        check_value("slot7_mem", mem[7], 32'h41DE_D852);
        check_value("bad_rate_sticky", {31'd0, bad_rate}, 32'd1);
        check_value("bad_rate_slot3_mem", mem[3], 32'h405E_D852);

        // Start pulse during a sweep is dropped
        check_value("overrun_clear", {31'd0, overrun}, 32'd0);
        clear_stats();
        @(negedge clk);
        timestep_start = 1'b1;
        @(negedge clk);
        timestep_start = 1'b0;
        repeat (10) @(negedge clk);
        timestep_start = 1'b1;
        @(negedge clk);
        timestep_start = 1'b0;
        check_value("overrun_set", {31'd0, overrun}, 32'd1);
        wait_done("overrun_done");
        repeat (10) @(negedge clk);
        check_value("overrun_done_pulses", done_cnt, 32'd1);
        check_value("overrun_cycles", busy_cnt, 32'd151);
        check_value("overrun_writes", wr_count, 32'd30);
        check_value("overrun_idle", {31'd0, busy}, 32'd0);
        check_value("overrun_slot3_mem", mem[3], 32'h3FDE_D852);
        $display("overrun: done_pulses=%0d writes=%0d", done_cnt, wr_count);

        // Reset mid-sweep aborts with no further writes
        clear_stats();
        @(negedge clk);
        timestep_start = 1'b1;
        @(negedge clk);
        timestep_start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        repeat (200) @(negedge clk);
        check_value("abort_writes", wr_count, 32'd0);
        check_value("abort_busy", {31'd0, busy}, 32'd0);
        check_value("abort_overrun", {31'd0, overrun}, 32'd0);
        check_value("abort_bad_rate", {31'd0, bad_rate}, 32'd0);
        check_value("abort_dec_valid", {31'd0, dec_valid}, 32'd0);
        $display("abort: writes_after_reset=%0d", wr_count);

        // init_start and timestep_start together: init wins
        clear_stats();
        @(negedge clk);
        init_start     = 1'b1;
        timestep_start = 1'b1;
        @(negedge clk);
        init_start     = 1'b0;
        timestep_start = 1'b0;
        check_value("both_overrun", {31'd0, overrun}, 32'd1);
        wait_done("both_done");
        check_value("both_writes", wr_count, 32'd30);
        check_value("both_cycles", busy_cnt, 32'd31);
        check_value("both_handshakes", hs_count, 32'd0);
        check_value("both_slot3_mem", mem[3], INIT_P);
        $display("init+timestep: writes=%0d busy=%0d", wr_count, busy_cnt);

        // Negative zero in slot 5
        mem[5] = 32'h8000_0000;
        run_sweep("zero_slot");
        check_value("zero_slot5_mem", mem[5], 32'h8000_0000);
        check_value("zero_slot6_writes", wr_per_addr[6], 32'd1);
`ifdef DECAY_SKIP_ZERO_EN
        check_value("zero_handshakes", hs_count, 32'd29);
        check_value("zero_writes", wr_count, 32'd29);
        check_value("zero_slot5_issues", issue_cnt[5], 32'd0);
        check_value("zero_slot5_writes", wr_per_addr[5], 32'd0);
        check_value("zero_cycles", busy_cnt, 32'd148);
`else
        check_value("zero_handshakes", hs_count, 32'd30);
        check_value("zero_writes", wr_count, 32'd30);
        check_value("zero_slot5_issues", issue_cnt[5], 32'd1);
        check_value("zero_slot5_writes", wr_per_addr[5], 32'd1);
        check_value("zero_cycles", busy_cnt, 32'd151);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
